multi_debouncer: RTL and testbench
==================================

// Module: multi_debouncer
// PURPOSE
//  N-channel push-button conditioner for the PONG board inputs (paddle up/down, serve, reset key).
//  Synchronises raw pins and debounces them with a shared sample tick and a per-channel stability counter.
//  Emits a clean level, one-CLK press/release pulses, and a per-channel toggle LED.
//  Sits between board pins and game control logic; replaces the per-button single-channel debouncer.
// PARAMETERS
//  N_CH          2       number of independent input channels
//  CE_DIV        250000  CLK cycles per sample tick (100 MHz -> 2.5 ms); >=1
//  STABLE_CNT    3       consecutive differing ticks required to accept a new level; >=1
//  REPEAT_DELAY  200     ticks held before first REPEAT pulse (AUTO_REPEAT_EN only); >=1
//  REPEAT_PERIOD 40      ticks between subsequent REPEAT pulses (AUTO_REPEAT_EN only); >=1
// PORTS
//  CLK          in   1     system clock
//  RESET        in   1     synchronous reset, active-low
//  P            in   N_CH  raw asynchronous button inputs, active-high
//  LEVEL        out  N_CH  debounced level
//  PRESS        out  N_CH  1-CLK pulse on debounced 0->1
//  RELEASE      out  N_CH  1-CLK pulse on debounced 1->0
//  LED          out  N_CH  toggles on each PRESS
//  REPEAT       out  N_CH  1-CLK auto-repeat pulse while held; constant 0 without AUTO_REPEAT_EN
//  SAMPLE_TICK  out  1     1-CLK pulse each sample tick (debug / reuse by game timers)
// BEHAVIOUR
//  - Reset (RESET==0 at CLK edge): sync FFs, divider, all counters, LEVEL, PRESS, RELEASE, LED,
//    REPEAT, SAMPLE_TICK all 0. Takes priority over everything; mid-debounce progress is discarded.
//  - Sync: each P bit through 2 FFs (S1->S2) every CLK; only S2 is used downstream.
//  - Divider: counter 0..CE_DIV-1, width $clog2(CE_DIV+1); SAMPLE_TICK=1 for the cycle it equals
//    CE_DIV-1, then wraps to 0. CE_DIV==1 -> SAMPLE_TICK high every cycle.
//  - Per channel, on SAMPLE_TICK only (counters hold otherwise):
//      S2==LEVEL -> stab_cnt<=0 (glitch shorter than STABLE_CNT ticks is rejected).
//      S2!=LEVEL and stab_cnt==STABLE_CNT-1 -> LEVEL<=S2, stab_cnt<=0.
//      S2!=LEVEL otherwise -> stab_cnt<=stab_cnt+1.
//  - PRESS/RELEASE are registered and assert in the same CLK where LEVEL first shows its new value,
//    for exactly one CLK; never both in one cycle on one channel.
//  - LED[i] <= ~LED[i] in the cycle after PRESS[i] goes high (registered off PRESS).
//  - Latency from a clean P edge to LEVEL change: between 2+(STABLE_CNT-1)*CE_DIV+1 and
//    2+STABLE_CNT*CE_DIV+1 CLKs depending on divider phase.
//  - Channels are fully independent; simultaneous changes on several channels pulse together.
//  - Button held through reset release: LEVEL starts 0, so a PRESS is generated after normal debounce.
// CONFIGURATION
//  AUTO_REPEAT_EN defined: per-channel rep_cnt counts SAMPLE_TICKs while LEVEL==1; cleared to 0
//    when LEVEL==0 or on PRESS. REPEAT pulses 1 CLK on the tick where rep_cnt reaches REPEAT_DELAY,
//    then every REPEAT_PERIOD ticks after while held; rep_cnt saturates/reloads, never wraps to
//    trigger spuriously. RELEASE stops repeats immediately (no REPEAT in or after the RELEASE cycle).
//  AUTO_REPEAT_EN undefined: no rep_cnt logic; REPEAT tied to 0; port list unchanged.
// TESTING  (bench params: N_CH=2, CE_DIV=4, STABLE_CNT=3, REPEAT_DELAY=5, REPEAT_PERIOD=2)
//  1 RESET=0 4 CLK with P=2'b11 -> all outputs 0; after RESET=1, LEVEL=2'b11 within 2+12+1 CLK,
//    PRESS=2'b11 for exactly 1 CLK, LED=2'b11 next CLK.
//  2 P[0] 0->1 held 40 CLK -> LEVEL[0] rises within 11..15 CLK, single PRESS[0] pulse; P[1]
//    outputs unchanged.
//  3 P[0] pulse 1->0->1 bouncing every 3 CLK for 30 CLK, then stable 1 -> no PRESS during bounce;
//    exactly one PRESS after stable; LED[0] toggles once.
//  4 P[0] released after press -> RELEASE[0] one CLK, LEVEL[0]=0, LED[0] unchanged; second press
//    -> LED[0] back to 0.
//  5 RESET=0 asserted for 1 CLK mid-count (stab_cnt=2) -> LEVEL stays 0, debounce restarts from 0
//    ticks.
//  6 AUTO_REPEAT_EN: hold P[1] 100 CLK -> first REPEAT[1] 5 ticks (20 CLK) after PRESS, then every
//    8 CLK; none after RELEASE. Without the macro REPEAT==0 throughout.

Source files
------------

// File: rtl/multi_debouncer.sv
// multi_debouncer: N-channel button synchroniser/debouncer with press/release pulses and toggle LEDs.
// Optional feature macro AUTO_REPEAT_EN adds per-channel auto-repeat pulses while a button is held.
module multi_debouncer #(
    parameter int N_CH          = 2,
    parameter int CE_DIV        = 250000,
    parameter int STABLE_CNT    = 3,
    parameter int REPEAT_DELAY  = 200,
    parameter int REPEAT_PERIOD = 40
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [N_CH-1:0] p_i,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] press_o,
    output logic [N_CH-1:0] release_o,
    output logic [N_CH-1:0] led_o,
    output logic [N_CH-1:0] repeat_o,
    output logic            sample_tick_o
);

    localparam int DIV_W = $clog2(CE_DIV + 1);
    localparam int CNT_W = $clog2(STABLE_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    if (CE_DIV < 1 || STABLE_CNT < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : gBadParams
        $error("multi_debouncer: CE_DIV, STABLE_CNT, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic [N_CH-1:0]  sync1_q;
    logic [N_CH-1:0]  sync2_q;
    logic [DIV_W-1:0] divCnt_q, divCnt_d;
    logic             tick_q, tick_d;
    logic [N_CH-1:0]  level_q, level_d;
    logic [N_CH-1:0]  press_q, press_d;
    logic [N_CH-1:0]  release_q, release_d;
    logic [N_CH-1:0]  led_q, led_d;
    logic [CNT_W-1:0] stabCnt_q [N_CH];
    logic [CNT_W-1:0] stabCnt_d [N_CH];

    // The tick is registered from the next divider value so it is high exactly while the
    // divider sits at CE_DIV-1, and is forced low by reset even when CE_DIV is 1.
    always_comb begin
        divCnt_d  = (divCnt_q == DIV_LAST) ? '0 : divCnt_q + DIV_W'(1);
        tick_d    = (divCnt_d == DIV_LAST);
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        led_d     = led_q ^ press_q;
        stabCnt_d = stabCnt_q;
        if (tick_q) begin
            for (int i = 0; i < N_CH; i++) begin
                if (sync2_q[i] == level_q[i]) begin
                    stabCnt_d[i] = '0;
                end else if (stabCnt_q[i] == CNT_LAST) begin
                    level_d[i]   = sync2_q[i];
                    press_d[i]   = sync2_q[i];
                    release_d[i] = ~sync2_q[i];
                    stabCnt_d[i] = '0;
                end else begin
                    stabCnt_d[i] = stabCnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            divCnt_q  <= '0;
            tick_q    <= 1'b0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            led_q     <= '0;
            for (int i = 0; i < N_CH; i++) begin
                stabCnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= p_i;
            sync2_q   <= sync1_q;
            divCnt_q  <= divCnt_d;
            tick_q    <= tick_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            led_q     <= led_d;
            for (int i = 0; i < N_CH; i++) begin
                stabCnt_q[i] <= stabCnt_d[i];
            end
        end
    end

    assign level_o       = level_q;
    assign press_o       = press_q;
    assign release_o     = release_q;
    assign led_o         = led_q;
    assign sample_tick_o = tick_q;

`ifdef AUTO_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_PERIOD);

    logic [REP_W-1:0] repCnt_q [N_CH];
    logic [REP_W-1:0] repCnt_d [N_CH];
    logic [N_CH-1:0]  armed_q, armed_d;
    logic [N_CH-1:0]  repeat_q, repeat_d;

    // Counting only while the level is 1 now and stays 1 means the release tick clears the
    // counter instead of firing, so no repeat can coincide with or follow a RELEASE.
    always_comb begin
        repCnt_d = repCnt_q;
        armed_d  = armed_q;
        repeat_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (!(level_q[i] && level_d[i])) begin
                repCnt_d[i] = '0;
                armed_d[i]  = 1'b0;
            end else if (tick_q) begin
                if ((repCnt_q[i] + REP_W'(1)) == (armed_q[i] ? REP_NEXT : REP_FIRST)) begin
                    repeat_d[i] = 1'b1;
                    repCnt_d[i] = '0;
                    armed_d[i]  = 1'b1;
                end else begin
                    repCnt_d[i] = repCnt_q[i] + REP_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            armed_q  <= '0;
            repeat_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                repCnt_q[i] <= '0;
            end
        end else begin
            armed_q  <= armed_d;
            repeat_q <= repeat_d;
            for (int i = 0; i < N_CH; i++) begin
                repCnt_q[i] <= repCnt_d[i];
            end
        end
    end

    assign repeat_o = repeat_q;
`else
    assign repeat_o = '0;
`endif

endmodule

// File: tb/tb_multi_debouncer.sv
// Scoreboard bench for multi_debouncer: directed button patterns push expected output events into a
// queue; an independent negedge monitor pops and compares every event the DUT presents.
module tb_multi_debouncer;

    localparam int N_CH          = 2;
    localparam int CE_DIV        = 4;
    localparam int STABLE_CNT    = 3;
    localparam int REPEAT_DELAY  = 5;
    localparam int REPEAT_PERIOD = 2;
`ifdef AUTO_REPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    typedef struct {
        int         cyc;
        logic [5:0] pulses;
        logic [1:0] level;
        logic [1:0] led;
    } evT;

    logic       clk    = 1'b0;
    logic       rst_ni = 1'b0;
    logic [1:0] p      = 2'b11;
    logic [1:0] level_o, press_o, release_o, led_o, repeat_o;
    logic       sample_tick_o;

    int         cyc        = 0;
    int         compared   = 0;
    int         mismatched = 0;
    int         rBase      = 0;
    logic       rstSeen    = 1'b0;
    logic [1:0] prevLed    = 2'b00;
    logic [1:0] curP       = 2'b11;
    logic [1:0] expLevel   = 2'b00;
    logic [1:0] expLed     = 2'b00;
    evT         expQ[$];

    multi_debouncer #(
        .N_CH(N_CH), .CE_DIV(CE_DIV), .STABLE_CNT(STABLE_CNT),
        .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .p_i(p),
        .level_o(level_o), .press_o(press_o), .release_o(release_o),
        .led_o(led_o), .repeat_o(repeat_o), .sample_tick_o(sample_tick_o)
    );

    always #5 clk = ~clk;

    // cyc is the number of rising edges so far; rstSeen is the reset level sampled at the last edge.
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rstSeen <= rst_ni;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%0h required=%0h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    // Any pulse or LED change outside a reset edge is an event and must match the queue head.
    always @(negedge clk) begin : monitor
        evT         e;
        logic [5:0] pulses;
        pulses = {press_o, release_o, repeat_o};
        if (rstSeen === 1'b1 && (pulses !== 6'b0 || led_o !== prevLed)) begin
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpectedEvent: actual cyc=%0d press=%b release=%b repeat=%b led=%b, required none",
                         cyc, press_o, release_o, repeat_o, led_o);
            end else begin
                e = expQ.pop_front();
                checkOutput("eventCycle", 32'(cyc), 32'(e.cyc));
                checkOutput("pressReleaseRepeat", 32'(pulses), 32'(e.pulses));
                checkOutput("level", 32'(level_o), 32'(e.level));
                checkOutput("led", 32'(led_o), 32'(e.led));
            end
        end
        prevLed = led_o;
    end

    // Edge on which a level change is accepted when P changed just after edge a: the new value
    // reaches S2 for edge a+3, counting starts on the next tick edge, STABLE_CNT ticks accept it.
    function automatic int acceptEdge(input int a);
        int k;
        k = (a + 3 - rBase + CE_DIV - 1) / CE_DIV;
        if (k < 1) k = 1;
        return rBase + k * CE_DIV + (STABLE_CNT - 1) * CE_DIV;
    endfunction

    task automatic pushEv(input int c, input logic [1:0] pr, input logic [1:0] rl, input logic [1:0] rp);
        evT e;
        expLevel = (expLevel | pr) & ~rl;
        e.cyc    = c;
        e.pulses = {pr, rl, rp};
        e.level  = expLevel;
        e.led    = expLed;
        expQ.push_back(e);
        if (pr != 2'b00) begin
            expLed   = expLed ^ pr;
            e.cyc    = c + 1;
            e.pulses = 6'b0;
            e.led    = expLed;
            expQ.push_back(e);
        end
    endtask

    task automatic pushRelease(input logic [1:0] mask, input int pe, input int re);
        if (REPEAT_ON) begin
            for (int e = pe + REPEAT_DELAY * CE_DIV; e < re; e += REPEAT_PERIOD * CE_DIV)
                pushEv(e, 2'b00, 2'b00, mask);
        end
        pushEv(re, 2'b00, mask, 2'b00);
    endtask

    task automatic driveP(input logic [1:0] v, output int edgeNo);
        @(posedge clk);
        #1;
        p      = v;
        curP   = v;
        edgeNo = cyc;
    endtask

    task automatic waitEdge(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
    endtask

    task automatic doReset(input int n);
        rst_ni = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rBase    = cyc;
        expLevel = 2'b00;
        expLed   = 2'b00;
        checkOutput("resetState",
                    32'({level_o, press_o, release_o, led_o, repeat_o, sample_tick_o}), 32'd0);
        rst_ni = 1'b1;
    endtask

    task automatic applyStimulus(input logic [1:0] mask, input int hold);
        int a, pe, re, relEdge;
        driveP(curP | mask, a);
        pe = acceptEdge(a);
        re = acceptEdge(a + hold);
        pushEv(pe, mask, 2'b00, 2'b00);
        pushRelease(mask, pe, re);
        repeat (hold - 1) @(posedge clk);
        driveP(curP & ~mask, relEdge);
        waitDrain(relEdge - a + 100);
    endtask

    initial begin
        int a, pe, re, e1;

        // Both buttons held through reset: divider phase check, then press on both and release.
        doReset(4);
        waitEdge(rBase + 2);
        @(negedge clk);
        checkOutput("tickBeforeWrap", 32'(sample_tick_o), 32'd0);
        waitEdge(rBase + 3);
        @(negedge clk);
        checkOutput("tickAtWrap", 32'(sample_tick_o), 32'd1);
        pe = acceptEdge(rBase);
        pushEv(pe, 2'b11, 2'b00, 2'b00);
        waitEdge(pe + 1);
        driveP(2'b00, a);
        re = acceptEdge(a);
        pushRelease(2'b11, pe, re);
        waitDrain(100);

        // Channel 0 held for 40 clocks.
        applyStimulus(2'b01, 40);

        // Channel 0 bouncing every 3 clocks, then a clean press.
        for (int s = 0; s < 10; s++) begin
            driveP((s % 2 == 0) ? 2'b01 : 2'b00, a);
            repeat (2) @(posedge clk);
        end
        repeat (8) @(posedge clk);
        applyStimulus(2'b01, 16);

        // Press/release held exactly up to the first repeat boundary.
        applyStimulus(2'b01, 20);

        // Reset pulse after two differing ticks: debounce restarts from zero.
        driveP(2'b01, a);
        e1 = acceptEdge(a) - (STABLE_CNT - 1) * CE_DIV;
        waitEdge(e1 + 5);
        doReset(1);
        pe = acceptEdge(rBase);
        pushEv(pe, 2'b01, 2'b00, 2'b00);
        waitEdge(pe + 1);
        driveP(2'b00, a);
        re = acceptEdge(a);
        pushRelease(2'b01, pe, re);
        waitDrain(100);

        // Long hold on channel 1.
        applyStimulus(2'b10, 100);

        repeat (40) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
